// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: routes one DW-bit word per slot into N_CH registered lanes.
// Optional TDM_DEMUX_DBL_BUF_EN buffers a frame in a shadow register and publishes it atomically.
module tdm_demux #(
   parameter int DW   = 8,
   parameter int N_CH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DW-1:0]        din,
   input  logic                 din_valid,
   input  logic                 sync,
   output logic [N_CH*DW-1:0]   dout,
   output logic                 frame_valid,
   output logic                 frame_err,
   output logic [$clog2(N_CH)-1:0] cur_slot
);

   localparam int CW = $clog2(N_CH);
   // Wrap is by compare, so non-power-of-two N_CH never relies on counter overflow.
   localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic {HUNT, RECV} state_t;

   state_t              state_p1, state_d;
   logic [CW-1:0]       cnt_p1, cnt_d;
   logic                cap_en;
   logic [CW-1:0]       cap_idx;
   logic                vld_d, err_d;
   logic                vld_p1, err_p1;
   logic [N_CH*DW-1:0]  lanes_base, lanes_merged;
   logic [N_CH*DW-1:0]  dout_p1, dout_d;
`ifdef TDM_DEMUX_DBL_BUF_EN
   logic [N_CH*DW-1:0]  shadow_p1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_p1 <= HUNT;
      else        state_p1 <= state_d;
   end

   always_comb begin
      state_d = state_p1;
      if (din_valid) begin
         case (state_p1)
            HUNT: if (sync) state_d = RECV;
            RECV: if (!sync && cnt_p1 == LAST) state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   // An early sync in RECV restarts the frame at slot 0 rather than dropping the word.
   always_comb begin
      cap_en  = 1'b0;
      cap_idx = '0;
      cnt_d   = cnt_p1;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      if (din_valid) begin
         case (state_p1)
            HUNT: begin
               if (sync) begin
                  cap_en = 1'b1;
                  cnt_d  = ONE;
               end
            end
            RECV: begin
               cap_en = 1'b1;
               if (sync) begin
                  err_d = 1'b1;
                  cnt_d = ONE;
               end else begin
                  cap_idx = cnt_p1;
                  if (cnt_p1 == LAST) begin
                     vld_d = 1'b1;
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_p1 + ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TDM_DEMUX_DBL_BUF_EN
   assign lanes_base = shadow_p1;
`else
   assign lanes_base = dout_p1;
`endif

   always_comb begin
      lanes_merged = lanes_base;
      for (int k = 0; k < N_CH; k++) begin
         if (cap_en && cap_idx == CW'(k)) lanes_merged[k*DW +: DW] = din;
      end
   end

`ifdef TDM_DEMUX_DBL_BUF_EN
   // The last word bypasses the shadow so the full frame lands in dout on the frame_valid edge.
   assign dout_d = vld_d ? lanes_merged : dout_p1;
`else
   assign dout_d = lanes_merged;
`endif

   // ---- stage p1: registered lanes, counter and event pulses ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1    <= '0;
         vld_p1    <= 1'b0;
         err_p1    <= 1'b0;
         dout_p1   <= '0;
`ifdef TDM_DEMUX_DBL_BUF_EN
         shadow_p1 <= '0;
`endif
      end else begin
         cnt_p1    <= cnt_d;
         vld_p1    <= vld_d;
         err_p1    <= err_d;
         dout_p1   <= dout_d;
`ifdef TDM_DEMUX_DBL_BUF_EN
         shadow_p1 <= lanes_merged;
`endif
      end
   end

   assign dout        = dout_p1;
   assign frame_valid = vld_p1;
   assign frame_err   = err_p1;
   assign cur_slot    = cnt_p1;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential 1-to-N time-division demultiplexer; the receive-side counterpart of the team's 2:1 selector, used at the far end of a shared link.
- Accepts a serial stream of DW-bit words, one per slot, with slot 0 flagged by sync.
- Routes each word into its own registered output lane.
- Flags a complete frame and any short frame (sync arriving mid-frame).

Parameters:
DW, 8, data word width in bits (>=1)
N_CH, 4, channels (slots) per frame (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  DW  incoming slot word
din_valid  input  1  din carries a word this cycle
sync  input  1  qualifies din as slot 0; ignored when din_valid=0
dout  output  N_CH*DW  output lanes; lane k = dout[k*DW +: DW]
frame_valid  output  1  one-cycle pulse: full frame delivered
frame_err  output  1  one-cycle pulse: frame aborted by early sync
cur_slot  output  $clog2(N_CH)  next expected slot index

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - On rst_n=0: state=HUNT, slot counter=0, dout=0, shadow=0, frame_valid=0, frame_err=0, cur_slot=0.
  - Reset is effective immediately; a partial frame in progress is discarded.
- FSM, 2 states, HUNT and RECV; all transitions on rising clk.
  - HUNT, din_valid=1 with sync=1: capture din as slot 0, counter<=1, go to RECV.
  - HUNT, din_valid=1 with sync=0: word dropped; no output change; stay in HUNT.
  - RECV, din_valid=1 with sync=0: capture din into slot=counter.
    - If counter==N_CH-1: frame_valid=1 on the next cycle, counter<=0, go to HUNT.
    - Otherwise: counter<=counter+1.
  - RECV, din_valid=1 with sync=1 (early sync): frame_err=1 on the next cycle.
    - Partial frame abandoned; no frame_valid.
    - din captured as slot 0 of a new frame, counter<=1, stay in RECV.
  - din_valid=0 in either state: hold. No state or counter change, no timeout; a frame may stall indefinitely.
- Back-to-back frames: after the last slot the FSM is in HUNT, so a sync word on the very next cycle is accepted with no bubble.
- Latency:
  - Lane data is registered and visible 1 cycle after its din_valid edge (live mode).
  - frame_valid is asserted 1 cycle after the last slot's edge.
- frame_valid and frame_err are mutually exclusive and never asserted for more than 1 cycle per event.
- cur_slot: registered counter value. 0 in HUNT; in RECV equals the index the next word will fill.
- Counter width is $clog2(N_CH). N_CH need not be a power of 2: the wrap is by compare to N_CH-1, never by overflow.
- sync is don't-care when din_valid=0 and must not affect state.

Optional Feature:
Macro TDM_DEMUX_DBL_BUF_EN.
- Defined:
  - Words are captured into an internal N_CH*DW shadow register.
  - dout loads the whole shadow atomically on the same edge that raises frame_valid, so dout changes only at frame_valid.
  - An aborted frame (frame_err) leaves dout completely unchanged.
- Undefined:
  - No shadow register; each lane of dout updates directly on its own capture (live mode).
  - After frame_err, lanes already written by the partial frame keep the new values; the other lanes keep their old values.

Test Plan:
- Reset: assert rst_n=0 mid-frame after slots 0,1 loaded -> dout=0, cur_slot=0, frame_valid=0 immediately (asynchronous); the next non-sync word is dropped.
- Nominal frame (DW=8, N_CH=4): words 0x11(sync),0x22,0x33,0x44 on 4 consecutive cycles -> frame_valid pulse 1 cycle after 0x44; dout=0x44332211; cur_slot sequence 1,2,3,0.
- Stall: the same frame with din_valid=0 for 3 cycles between 0x22 and 0x33 -> identical dout; frame_valid delayed by exactly 3 cycles; cur_slot holds at 2 during the stall.
- Early sync: 0xA1(sync),0xA2, then 0xB1(sync),0xB2,0xB3,0xB4 -> frame_err pulse after 0xB1, frame_valid after 0xB4, final dout=0xB4B3B2B1.
  - With TDM_DEMUX_DBL_BUF_EN: dout does not change before that frame_valid.
- Hunt drop and back-to-back: 0x55,0x66 without sync in HUNT -> ignored, cur_slot=0. Then two sync frames with no gap -> two frame_valid pulses exactly 4 cycles apart.
- Live mode (macro undefined): after 0x11(sync) lane 0=0x11 one cycle later while frame_valid=0; with the macro defined, lane 0 stays at its previous value until frame_valid.
